// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core instruction sequencer: state encodings,
// instruction bit positions and a helper that packs instruction fields.
package core_ctrl_pkg;

    localparam int INST_W = 34;
    localparam int A_W    = 11;

    // Instruction word bit positions
    localparam int ACC_B      = 33;
    localparam int CEN_P_B    = 32;
    localparam int WEN_P_B    = 31;
    localparam int A_P_LSB    = 20;
    localparam int CEN_X_B    = 19;
    localparam int WEN_X_B    = 18;
    localparam int A_X_LSB    = 7;
    localparam int OFIFO_RD_B = 6;
    localparam int IFIFO_WR_B = 5;
    localparam int IFIFO_RD_B = 4;
    localparam int L0_RD_B    = 3;
    localparam int L0_WR_B    = 2;
    localparam int EXEC_B     = 1;
    localparam int LOAD_B     = 0;

    // Sequencer states
    typedef logic [3:0] state_t;
    localparam state_t ST_IDLE  = 4'd0;
    localparam state_t ST_CLR   = 4'd1;
    localparam state_t ST_W_L0  = 4'd2;
    localparam state_t ST_LOAD  = 4'd3;
    localparam state_t ST_GAP   = 4'd4;
    localparam state_t ST_X_L0  = 4'd5;
    localparam state_t ST_EXEC  = 4'd6;
    localparam state_t ST_DRAIN = 4'd7;
    localparam state_t ST_ACC   = 4'd8;
    localparam state_t ST_DONE  = 4'd9;

    typedef struct packed {
        logic           acc;
        logic           cen_pmem;
        logic           wen_pmem;
        logic [A_W-1:0] a_pmem;
        logic           cen_xmem;
        logic           wen_xmem;
        logic [A_W-1:0] a_xmem;
        logic           ofifo_rd;
        logic           ififo_wr;
        logic           ififo_rd;
        logic           l0_rd;
        logic           l0_wr;
        logic           execute;
        logic           load;
    } inst_t;

    // Both memories deselected and write-disabled, everything else quiet
    localparam logic [INST_W-1:0] INST_IDLE = (34'd1 << CEN_P_B) | (34'd1 << WEN_P_B) |
                                              (34'd1 << CEN_X_B) | (34'd1 << WEN_X_B);

    function automatic inst_t idle_fields();
        inst_t f;
        f          = '0;
        f.cen_pmem = 1'b1;
        f.wen_pmem = 1'b1;
        f.cen_xmem = 1'b1;
        f.wen_xmem = 1'b1;
        return f;
    endfunction

    // Explicit placement so the word layout does not depend on struct order
    function automatic logic [INST_W-1:0] pack_inst(input inst_t f);
        logic [INST_W-1:0] w;
        w                     = '0;
        w[ACC_B]              = f.acc;
        w[CEN_P_B]            = f.cen_pmem;
        w[WEN_P_B]            = f.wen_pmem;
        w[A_P_LSB +: A_W]     = f.a_pmem;
        w[CEN_X_B]            = f.cen_xmem;
        w[WEN_X_B]            = f.wen_xmem;
        w[A_X_LSB +: A_W]     = f.a_xmem;
        w[OFIFO_RD_B]         = f.ofifo_rd;
        w[IFIFO_WR_B]         = f.ififo_wr;
        w[IFIFO_RD_B]         = f.ififo_rd;
        w[L0_RD_B]            = f.l0_rd;
        w[L0_WR_B]            = f.l0_wr;
        w[EXEC_B]             = f.execute;
        w[LOAD_B]             = f.load;
        return w;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/core_ctrl_if.sv
// Host handshake and core-facing instruction bus of the sequencer.
interface core_ctrl_if;
    import core_ctrl_pkg::*;

    logic              start;
    logic              ofifo_valid;
    logic [INST_W-1:0] inst;
    logic              core_clr;
    logic              busy;
    logic              done;
    logic [3:0]        kij_idx;
    logic              sfp_valid;

    modport master (
        input  start, ofifo_valid,
        output inst, core_clr, busy, done, kij_idx, sfp_valid
    );

    modport slave (
        output start, ofifo_valid,
        input  inst, core_clr, busy, done, kij_idx, sfp_valid
    );
endinterface

// File: rtl/core_ctrl_seq_cnt.sv
// Loadable up-counter with a terminal-count flag compared against a
// run-time terminal value.
module core_ctrl_seq_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    input  logic [W-1:0] tc_val_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);
    logic [W-1:0] cnt_q, cnt_d;

    // Load has priority over increment
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (inc_i)
            cnt_d = cnt_q + W'(1);
    end

    // Counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == tc_val_i);
endmodule

// File: rtl/core_ctrl.sv
// Instruction sequencer for one output tile of core: per-kij weight/activation
// staging, execution and OFIFO drain, then the SFP accumulation pass.
// Every output is registered, so outputs trail the internal state by one cycle.
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int row      = 8,
    parameter int col      = 8,
    parameter int len_nij  = 36,
    parameter int len_onij = 16,
    parameter int len_kij  = 9,
    parameter int addr_bw  = 11,
    parameter int W_BASE   = 1024,
    parameter int gap_cyc  = 10,
    parameter int clr_cyc  = 10
) (
    input  logic        clk,
    input  logic        reset,
    core_ctrl_if.master bus
);
    localparam int T_MAX = max_int(max_int(max_int(clr_cyc - 1, col), max_int(row, gap_cyc - 1)),
                                   max_int(len_nij, len_kij + 3));
    localparam int TW    = $clog2(T_MAX + 1);
    localparam int OW    = (len_onij > 1) ? $clog2(len_onij) : 1;
    localparam int KW    = (len_kij > 1) ? $clog2(len_kij) : 1;
    localparam int A_MSK = (1 << addr_bw) - 1;

    state_t state_q, state_d;
    logic   armed_q;

    logic [TW-1:0] t_cnt, t_last;
    logic [OW-1:0] o_cnt;
    logic [KW-1:0] j_cnt, k_cnt;
    logic          t_tc, o_tc, j_tc, k_tc;
    logic          t_load, t_inc, o_load, o_inc, j_load, j_inc, k_load, k_inc;
    logic          rd_phase;
    int            t_v, o_v, j_v, k_v;

    inst_t             f;
    logic              clr_d, busy_d, done_d, sfp_d;
    logic [INST_W-1:0] inst_q;
    logic              core_clr_q, busy_q, done_q, sfp_q;
    logic [3:0]        kij_q;

    core_ctrl_seq_cnt #(.W(TW)) u_t_cnt (
        .clk(clk), .reset(reset), .load_i(t_load), .load_val_i('0), .inc_i(t_inc),
        .tc_val_i(t_last), .cnt_o(t_cnt), .tc_o(t_tc)
    );
    core_ctrl_seq_cnt #(.W(OW)) u_o_cnt (
        .clk(clk), .reset(reset), .load_i(o_load), .load_val_i('0), .inc_i(o_inc),
        .tc_val_i(OW'(len_onij - 1)), .cnt_o(o_cnt), .tc_o(o_tc)
    );
    core_ctrl_seq_cnt #(.W(KW)) u_j_cnt (
        .clk(clk), .reset(reset), .load_i(j_load), .load_val_i('0), .inc_i(j_inc),
        .tc_val_i(KW'(len_kij - 1)), .cnt_o(j_cnt), .tc_o(j_tc)
    );
    core_ctrl_seq_cnt #(.W(KW)) u_k_cnt (
        .clk(clk), .reset(reset), .load_i(k_load), .load_val_i('0), .inc_i(k_inc),
        .tc_val_i(KW'(len_kij - 1)), .cnt_o(k_cnt), .tc_o(k_tc)
    );

    assign t_v      = int'(t_cnt);
    assign o_v      = int'(o_cnt);
    assign j_v      = int'(j_cnt);
    assign k_v      = int'(k_cnt);
    // ACC step 0 clears, steps 1..len_kij read the stored partial sums
    assign rd_phase = (t_v >= 1) && (t_v <= len_kij);

    // Next-state and counter control
    always_comb begin
        state_d = state_q;
        t_last  = '0;
        t_load  = 1'b0;
        t_inc   = 1'b0;
        o_load  = 1'b0;
        o_inc   = 1'b0;
        j_load  = 1'b0;
        j_inc   = 1'b0;
        k_load  = 1'b0;
        k_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && armed_q) begin
                    state_d = ST_CLR;
                    t_load  = 1'b1;
                    o_load  = 1'b1;
                    j_load  = 1'b1;
                    k_load  = 1'b1;
                end
            end
            ST_CLR: begin
                t_last = TW'(clr_cyc - 1);
                t_inc  = 1'b1;
                if (t_tc) begin
                    t_load  = 1'b1;
                    state_d = ST_W_L0;
                end
            end
            ST_W_L0: begin
                t_last = TW'(col);
                t_inc  = 1'b1;
                if (t_tc) begin
                    t_load  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                t_last = TW'(row);
                t_inc  = 1'b1;
                if (t_tc) begin
                    t_load  = 1'b1;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                t_last = TW'(gap_cyc - 1);
                t_inc  = 1'b1;
                if (t_tc) begin
                    t_load  = 1'b1;
                    state_d = ST_X_L0;
                end
            end
            ST_X_L0: begin
                t_last = TW'(len_nij);
                t_inc  = 1'b1;
                if (t_tc) begin
                    t_load  = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                t_last = TW'(len_nij);
                t_inc  = 1'b1;
                if (t_tc) begin
                    t_load  = 1'b1;
                    o_load  = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Only cycles with a valid OFIFO word advance the drain
                if (bus.ofifo_valid) begin
                    if (o_tc) begin
                        o_load = 1'b1;
                        t_load = 1'b1;
                        if (k_tc) begin
                            j_load  = 1'b1;
                            state_d = ST_ACC;
                        end else begin
                            k_inc   = 1'b1;
                            state_d = ST_CLR;
                        end
                    end else begin
                        o_inc = 1'b1;
                    end
                end
            end
            ST_ACC: begin
                t_last = TW'(len_kij + 3);
                t_inc  = 1'b1;
                if (t_v == 0)
                    j_load = 1'b1;
                else if (rd_phase && !j_tc)
                    j_inc = 1'b1;
                if (t_tc) begin
                    t_load = 1'b1;
                    if (o_tc)
                        state_d = ST_DONE;
                    else
                        o_inc = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode for the current state, registered below
    always_comb begin
        f      = idle_fields();
        clr_d  = 1'b0;
        sfp_d  = 1'b0;
        done_d = 1'b0;
        busy_d = (state_q != ST_IDLE) && (state_q != ST_DONE);
        case (state_q)
            ST_CLR: clr_d = 1'b1;
            ST_W_L0: begin
                if (t_v < col) begin
                    f.cen_xmem = 1'b0;
                    f.a_xmem   = A_W'((W_BASE + k_v * col + t_v) & A_MSK);
                end
                // SRAM data arrives one cycle after the address
                if (t_v >= 1)
                    f.l0_wr = 1'b1;
            end
            ST_LOAD: begin
                f.load  = 1'b1;
                f.l0_rd = 1'b1;
            end
            ST_X_L0: begin
                if (t_v < len_nij) begin
                    f.cen_xmem = 1'b0;
                    f.a_xmem   = A_W'(t_v & A_MSK);
                end
                if (t_v >= 1)
                    f.l0_wr = 1'b1;
            end
            ST_EXEC: begin
                f.execute  = 1'b1;
                f.ififo_rd = 1'b1;
            end
            ST_DRAIN: begin
                if (bus.ofifo_valid) begin
                    f.ofifo_rd = 1'b1;
                    f.cen_pmem = 1'b0;
                    f.wen_pmem = 1'b0;
                    f.a_pmem   = A_W'((k_v * len_onij + o_v) & A_MSK);
                end
            end
            ST_ACC: begin
                if (t_v == 0)
                    clr_d = 1'b1;
                if (rd_phase) begin
                    f.cen_pmem = 1'b0;
                    f.a_pmem   = A_W'((j_v * len_onij + o_v) & A_MSK);
                end
                // Accumulate runs one cycle behind the reads
                if ((t_v >= 2) && (t_v <= len_kij + 1))
                    f.acc = 1'b1;
                if (t_v == len_kij + 3)
                    sfp_d = 1'b1;
            end
            ST_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    // State register; armed_q masks a start on the first edge after reset release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst_q     <= INST_IDLE;
            core_clr_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sfp_q      <= 1'b0;
            kij_q      <= '0;
        end else begin
            inst_q     <= pack_inst(f);
            core_clr_q <= clr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sfp_q      <= sfp_d;
            kij_q      <= 4'(k_cnt);
        end
    end

    assign bus.inst      = inst_q;
    assign bus.core_clr  = core_clr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sfp_valid = sfp_q;
    assign bus.kij_idx   = kij_q;
endmodule
